ppi_8255: RTL

- Programmable peripheral interface: successor to the fixed-direction PIA model at 0xB0xx.
- Adds programmable port directions via control word, port C bit set/reset, and mode 1 strobed handshake on port A.
- Sits on the registered CPU bus (address/rnw/cpu_dout) and is clocked by the CPU clock.
- Drives keyboard row, VDG mode and sound/cassette lines through pa/pb/pc outputs, and raises intr_a toward the future VIA/IRQ logic.

---
 rtl/ppi_pkg.sv | 45 ++++
 rtl/ppi_8255_edge_sync.sv | 33 +++
 rtl/ppi_8255.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ppi_pkg.sv
// Shared constants and helpers for the ppi_8255 programmable peripheral interface.
package ppi_pkg;

    localparam logic [1:0] ADDR_A    = 2'b00;
    localparam logic [1:0] ADDR_B    = 2'b01;
    localparam logic [1:0] ADDR_C    = 2'b10;
    localparam logic [1:0] ADDR_CTRL = 2'b11;

    localparam int unsigned CTRL_FLAG    = 7;
    localparam int unsigned CTRL_AMODE_H = 6;
    localparam int unsigned CTRL_AMODE_L = 5;
    localparam int unsigned CTRL_ADIR    = 4;
    localparam int unsigned CTRL_CUDIR   = 3;
    localparam int unsigned CTRL_BMODE   = 2;
    localparam int unsigned CTRL_BDIR    = 1;
    localparam int unsigned CTRL_CLDIR   = 0;

    localparam logic [7:0] CTRL_RESET_DEF = 8'h9B;

    localparam int unsigned PC_INTR_A = 3;
    localparam int unsigned PC_STB_A  = 4;
    localparam int unsigned PC_IBF_A  = 5;
    localparam int unsigned PC_ACK_A  = 6;
    localparam int unsigned PC_OBF_A  = 7;

    typedef enum logic [1:0] {
        HsNone = 2'b00,
        HsIn   = 2'b01,
        HsOut  = 2'b10
    } hs_mode_e;

    // Mode 2 encodings fall back to mode 1 behaviour.
    function automatic hs_mode_e hs_mode(input logic [7:0] ctrl);
        hs_mode_e m;
        if (ctrl[CTRL_AMODE_H:CTRL_AMODE_L] == 2'b00) begin
            m = HsNone;
        end else if (ctrl[CTRL_ADIR]) begin
            m = HsIn;
        end else begin
            m = HsOut;
        end
        return m;
    endfunction

endpackage

// File: rtl/ppi_8255_edge_sync.sv
// Multi-stage synchroniser for a handshake pin with registered edge pulses.
module ppi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rise;
    logic                   r_fall;

    // Pulses are computed from the last two stages so they land on the same
    // edge as the final stage toggles, giving SYNC_STAGES+1 to a flag change.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= '1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_rise <= ~r_sync[SYNC_STAGES-1] & r_sync[SYNC_STAGES-2];
            r_fall <= r_sync[SYNC_STAGES-1] & ~r_sync[SYNC_STAGES-2];
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/ppi_8255.sv
// 8255-style PPI: programmable port directions, port C bit set/reset and
// mode 1 strobed handshake on port A.
module ppi_8255
    import ppi_pkg::*;
#(
    parameter int         DATA_W      = 8,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CTRL_RESET  = CTRL_RESET_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_cs,
    input  logic              i_rnw,
    input  logic [1:0]        i_addr,
    input  logic [7:0]        i_din,
    output logic [7:0]        o_dout,
    input  logic [DATA_W-1:0] i_pa_in,
    output logic [DATA_W-1:0] o_pa_out,
    output logic [DATA_W-1:0] o_pa_oe,
    input  logic [DATA_W-1:0] i_pb_in,
    output logic [DATA_W-1:0] o_pb_out,
    output logic [DATA_W-1:0] o_pb_oe,
    input  logic [7:0]        i_pc_in,
    output logic [7:0]        o_pc_out,
    output logic [7:0]        o_pc_oe,
    output logic              o_intr_a
);

    logic [7:0]        r_ctrl;
    logic [DATA_W-1:0] r_pa_out;
    logic [DATA_W-1:0] r_pb_out;
    logic [7:0]        r_pc_out;
    logic [DATA_W-1:0] r_pa_latch;
    logic              r_ibf;
    logic              r_intr;
    logic              r_obf_n;
    logic              r_inte;
    logic              r_rd_pend;

    logic              w_wr;
    logic              w_rd;
    logic              w_wr_a;
    logic              w_wr_b;
    logic              w_wr_c;
    logic              w_wr_ctrl;
    logic              w_bsr;
    logic              w_bsr_inte;
    logic              w_rd_a;
    logic              w_stb_rise;
    logic              w_stb_fall;
    logic              w_ack_rise;
    logic              w_ack_fall;
    hs_mode_e          w_mode;
    logic [7:0]        w_pc_drv;
    logic [7:0]        w_pc_oe;
    logic [7:0]        w_pc_rd;
    logic [DATA_W-1:0] w_pa_rd;
    logic [DATA_W-1:0] w_pb_rd;

    ppi_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_stb_sync (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_d      (i_pc_in[PC_STB_A]),
        .o_rise   (w_stb_rise),
        .o_fall   (w_stb_fall)
    );

    ppi_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_d      (i_pc_in[PC_ACK_A]),
        .o_rise   (w_ack_rise),
        .o_fall   (w_ack_fall)
    );

    assign w_mode    = hs_mode(r_ctrl);
    assign w_wr      = i_cs & ~i_rnw;
    assign w_rd      = i_cs & i_rnw;
    assign w_wr_a    = w_wr && (i_addr == ADDR_A);
    assign w_wr_b    = w_wr && (i_addr == ADDR_B);
    assign w_wr_c    = w_wr && (i_addr == ADDR_C);
    assign w_wr_ctrl = w_wr && (i_addr == ADDR_CTRL) && i_din[CTRL_FLAG];
    assign w_bsr     = w_wr && (i_addr == ADDR_CTRL) && !i_din[CTRL_FLAG];
    assign w_rd_a    = w_rd && (i_addr == ADDR_A);

    // In mode 1 the INTE_A enable lives behind the ACK/STB pin's BSR address.
    assign w_bsr_inte = w_bsr &&
        ((w_mode == HsIn  && i_din[3:1] == 3'(PC_STB_A)) ||
         (w_mode == HsOut && i_din[3:1] == 3'(PC_ACK_A)));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ctrl     <= CTRL_RESET;
            r_pa_out   <= '0;
            r_pb_out   <= '0;
            r_pc_out   <= 8'h00;
            r_pa_latch <= '0;
            r_ibf      <= 1'b0;
            r_intr     <= 1'b0;
            r_obf_n    <= 1'b1;
            r_inte     <= 1'b0;
            r_rd_pend  <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_ctrl    <= i_din;
            r_pa_out  <= '0;
            r_pb_out  <= '0;
            r_pc_out  <= 8'h00;
            r_ibf     <= 1'b0;
            r_intr    <= 1'b0;
            r_obf_n   <= 1'b1;
            r_inte    <= 1'b0;
            r_rd_pend <= 1'b0;
        end else begin
            if (w_wr_a) r_pa_out <= i_din[DATA_W-1:0];
            if (w_wr_b) r_pb_out <= i_din[DATA_W-1:0];
            if (w_wr_c) r_pc_out <= i_din;
            if (w_bsr && !w_bsr_inte) r_pc_out[i_din[3:1]] <= i_din[0];
            if (w_bsr_inte) r_inte <= i_din[0];
            r_rd_pend <= 1'b0;

            case (w_mode)
                HsIn: begin
                    if (w_stb_rise && r_ibf && r_inte) r_intr <= 1'b1;
                    // A read drops INTR first and IBF one cycle later.
                    if (w_rd_a) begin
                        r_intr    <= 1'b0;
                        r_rd_pend <= 1'b1;
                    end
                    if (r_rd_pend) r_ibf <= 1'b0;
                    if (w_stb_fall) begin
                        r_pa_latch <= i_pa_in;
                        r_ibf      <= 1'b1;
                        r_rd_pend  <= 1'b0;
                    end
                end
                HsOut: begin
                    if (w_ack_fall) r_obf_n <= 1'b1;
                    if (w_ack_rise) r_intr <= r_inte;
                    if (w_wr_a) begin
                        r_obf_n <= 1'b0;
                        r_intr  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_pc_oe  = {{4{~r_ctrl[CTRL_CUDIR]}}, {4{~r_ctrl[CTRL_CLDIR]}}};
        w_pc_drv = r_pc_out;
        case (w_mode)
            HsIn: begin
                w_pc_oe[PC_INTR_A]  = 1'b1;
                w_pc_oe[PC_STB_A]   = 1'b0;
                w_pc_oe[PC_IBF_A]   = 1'b1;
                w_pc_drv[PC_INTR_A] = r_intr;
                w_pc_drv[PC_IBF_A]  = r_ibf;
            end
            HsOut: begin
                w_pc_oe[PC_INTR_A]  = 1'b1;
                w_pc_oe[PC_ACK_A]   = 1'b0;
                w_pc_oe[PC_OBF_A]   = 1'b1;
                w_pc_drv[PC_INTR_A] = r_intr;
                w_pc_drv[PC_OBF_A]  = r_obf_n;
            end
            default: begin
            end
        endcase

        w_pc_rd = (w_pc_oe & w_pc_drv) | (~w_pc_oe & i_pc_in);
        if (w_mode == HsIn)  w_pc_rd[PC_STB_A] = r_inte;
        if (w_mode == HsOut) w_pc_rd[PC_ACK_A] = r_inte;
    end

    assign w_pa_rd = (w_mode == HsIn) ? r_pa_latch :
                     (r_ctrl[CTRL_ADIR] ? i_pa_in : r_pa_out);
    assign w_pb_rd = r_ctrl[CTRL_BDIR] ? i_pb_in : r_pb_out;

    always_comb begin
        o_dout = 8'h00;
        if (i_cs) begin
            case (i_addr)
                ADDR_A:  o_dout[DATA_W-1:0] = w_pa_rd;
                ADDR_B:  o_dout[DATA_W-1:0] = w_pb_rd;
                ADDR_C:  o_dout = w_pc_rd;
                default: o_dout = r_ctrl;
            endcase
        end
    end

    assign o_pa_out = r_pa_out;
    assign o_pa_oe  = {DATA_W{~r_ctrl[CTRL_ADIR]}};
    assign o_pb_out = r_pb_out;
    assign o_pb_oe  = {DATA_W{~r_ctrl[CTRL_BDIR]}};
    assign o_pc_out = w_pc_drv;
    assign o_pc_oe  = w_pc_oe;
    assign o_intr_a = r_intr;

endmodule
